minimac3_rx: RTL and testbench
==============================

Name: minimac3_rx

Overview:
- Parametrised MII receive engine for the minimac Ethernet core; runs entirely in the PHY receive clock domain.
- Strips preamble/SFD, assembles nibbles into bytes and writes each frame into one of SLOTS host-owned slot buffers.
- Drops frames when no slot is free, when a frame is too long, or when a frame is empty.
- Reports per-slot byte count, completion and, optionally, error status.

Parameters:
- SLOTS, 4: number of slot buffers (1..8).
- ADR_WIDTH, 11: buffer address width; each slot holds 2^ADR_WIDTH bytes.
- MAX_LEN, 1536: maximum stored frame length in bytes; must be ≤ 2^ADR_WIDTH.

Ports:
- phy_rx_clk  in  1  receive clock; all logic is on its rising edge.
- phy_rx_rst  in  1  reset, asynchronous, active-high.
- rx_ready  in  SLOTS  one-cycle pulse per slot: host hands that slot to the engine.
- rx_done  out  SLOTS  one-cycle pulse: frame complete in that slot.
- rx_count  out  SLOTS*ADR_WIDTH  byte count of slot k at bits [k*ADR_WIDTH +: ADR_WIDTH].
- rx_error  out  SLOTS  per-slot frame error flag (see Optional Feature).
- rx_dropped  out  1  one-cycle pulse: a frame was discarded.
- rxb_dat  out  8  write data, shared by all slots.
- rxb_adr  out  ADR_WIDTH  write address, shared by all slots.
- rxb_we  out  SLOTS  one-hot write enable selecting the target slot.
- phy_dv  in  1  MII RX_DV.
- phy_rx_data  in  4  MII RXD; low nibble of each byte arrives first.
- phy_rx_er  in  1  MII RX_ER.

Behaviour:
- Reset values: all outputs 0; state IDLE; slot-availability register 0; all counts 0.
- Slot availability:
  - avail <= (avail | rx_ready) & ~rx_done.
  - If rx_done and rx_ready hit the same bit in the same cycle, rx_done wins.
- Slot selection: at SFD, take the lowest-index set bit of avail and latch it as cur_slot (one-hot).
  - rx_count[cur_slot] <= 0 at that edge.
  - rx_error[cur_slot] <= 0 at that edge.
- States:
  - IDLE: if phy_dv=0, stay.
    - dv=1, nibble 0x5 -> PREAMBLE.
    - dv=1, nibble 0xD -> SFD handling.
    - dv=1, any other nibble -> DISCARD.
  - PREAMBLE:
    - dv=0 -> IDLE, silently; no drop pulse.
    - nibble 0x5 -> stay.
    - nibble 0xD -> SFD handling.
    - any other nibble -> DISCARD.
  - SFD handling: if avail=0 -> DISCARD; otherwise latch slot, then -> LOAD_LO.
  - LOAD_LO:
    - dv=1: latch lo nibble -> LOAD_HI.
    - dv=0: if count=0 -> DROP, else -> TERMINATE.
  - LOAD_HI:
    - dv=1 and count < MAX_LEN: latch hi nibble, request a write -> LOAD_LO.
    - dv=1 and count = MAX_LEN -> DISCARD; the frame is too long.
    - dv=0: the trailing odd nibble is discarded; count=0 -> DROP, else -> TERMINATE.
  - DISCARD: wait until dv=0 -> DROP. No writes, no rx_done; the selected slot stays available.
  - DROP: rx_dropped=1 for one cycle -> IDLE.
  - TERMINATE: rx_done[cur_slot]=1 for one cycle -> IDLE.
- Write timing: registered.
  - In the cycle after the hi nibble is sampled: rxb_we=cur_slot, rxb_adr=count, rxb_dat={hi,lo}.
  - rx_count[cur_slot] increments on that same edge.
  - rxb_we is never asserted outside LOAD_LO/LOAD_HI.
- Ordering: the last write completes no later than the edge at which TERMINATE asserts rx_done.
  - When rx_done pulses, rx_count holds the final byte count.
  - rx_count holds its value until the slot is selected again.
- Mid-frame reset: everything returns to reset values and all slots become unavailable.
  - A frame still in progress after reset release is handled by IDLE/PREAMBLE rules; mid-frame data nibbles lead to DISCARD and then a drop pulse.
- SLOTS=1: selection degenerates to the single slot; behaviour is otherwise identical.

Optional Feature:
- Macro: MINIMAC3_RX_ERR_EN.
- Defined:
  - phy_rx_er=1 in any cycle while in LOAD_LO/LOAD_HI sets rx_error[cur_slot].
  - An odd trailing nibble at dv fall also sets it.
  - The flag is valid when rx_done pulses; the frame is still delivered.
- Undefined:
  - rx_error is tied to 0.
  - phy_rx_er is ignored.
  - Odd trailing nibbles are discarded silently.

Test Plan:
- Normal frame: pulse rx_ready[2]; send 15×0x5, 0xD, then bytes 0x11..0x4C (60 bytes) -> 60 writes to slot 2 at adr 0..59 with correct data; rx_done=0b0100 pulse; rx_count slot 2 = 60.
- Lowest-slot pick and exhaustion: ready slots 1 and 3; send three 64-byte frames -> frames 1 and 2 land in slots 1 then 3; frame 3 gives rxb_we never set and one rx_dropped pulse.
- Too long (MAX_LEN=1536): send a 1600-byte frame -> 1536 writes, then DISCARD; rx_dropped pulse, no rx_done; the slot is still available for the next 64-byte frame, which yields rx_done.
- Runt/odd ending: SFD then dv drops -> rx_dropped, no rx_done; a 10-byte frame plus one extra nibble -> rx_count 10 and rx_done; with MINIMAC3_RX_ERR_EN, rx_error=1.
- Simultaneous events and reset: rx_ready[0] in the same cycle as rx_done[0] -> slot 0 is unavailable afterwards. Assert phy_rx_rst for 3 cycles mid-frame -> all outputs 0; the rest of that frame gives DISCARD, one rx_dropped and no writes.
- Error flag (macro on): phy_rx_er=1 for one cycle at byte 20 of a 64-byte frame -> rx_done with rx_error[slot]=1; the next clean frame into the same slot clears it to 0.

Source files
------------

// File: rtl/minimac3_rx_if.sv
// minimac3_rx_if: slot handshake, buffer write bus and MII receive pins of minimac3_rx.
interface minimac3_rx_if #(
  parameter int SLOTS = 4,
  parameter int ADR_WIDTH = 11
);
  logic [SLOTS-1:0] rx_ready;
  logic [SLOTS-1:0] rx_done;
  logic [SLOTS*ADR_WIDTH-1:0] rx_count;
  logic [SLOTS-1:0] rx_error;
  logic rx_dropped;
  logic [7:0] rxb_dat;
  logic [ADR_WIDTH-1:0] rxb_adr;
  logic [SLOTS-1:0] rxb_we;
  logic phy_dv;
  logic [3:0] phy_rx_data;
  logic phy_rx_er;
  modport master (
    input rx_ready, phy_dv, phy_rx_data, phy_rx_er,
    output rx_done, rx_count, rx_error, rx_dropped, rxb_dat, rxb_adr, rxb_we
  );
  modport slave (
    output rx_ready, phy_dv, phy_rx_data, phy_rx_er,
    input rx_done, rx_count, rx_error, rx_dropped, rxb_dat, rxb_adr, rxb_we
  );
endinterface

// File: rtl/minimac3_rx.sv
// minimac3_rx: MII receive engine writing frames into host-owned slot buffers.
// Define MINIMAC3_RX_ERR_EN to flag RX_ER and odd trailing nibbles in rx_error.
module minimac3_rx #(
  parameter int SLOTS = 4,
  parameter int ADR_WIDTH = 11,
  parameter int MAX_LEN = 1536
) (
  input logic phy_rx_clk,
  input logic phy_rx_rst,
  minimac3_rx_if.master bus
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, LOAD_LO, LOAD_HI, DISCARD, DROP, TERMINATE} state_t;
  localparam logic [ADR_WIDTH:0] MAX = (ADR_WIDTH+1)'(MAX_LEN);
  localparam logic [ADR_WIDTH:0] ONE = (ADR_WIDTH+1)'(1);
  state_t state, next;
  logic [SLOTS-1:0] avail, sel, cur, done, we;
  logic [SLOTS*ADR_WIDTH-1:0] counts;
  logic [ADR_WIDTH:0] cnt, cnt_inc;
  logic [ADR_WIDTH-1:0] adr;
  logic [7:0] dat;
  logic [3:0] lo;
  logic take, wr;
  // lowest set bit of avail, one-hot
  assign sel = avail & (~avail + SLOTS'(1));
  assign cnt_inc = cnt + ONE;
  assign done = state == TERMINATE ? cur : '0;
  always_comb begin
    next = state;
    take = 1'b0;
    wr = 1'b0;
    case (state)
      IDLE, PREAMBLE: begin
        take = bus.phy_dv && bus.phy_rx_data == 4'hd && |avail;
        next = !bus.phy_dv ? IDLE : bus.phy_rx_data == 4'h5 ? PREAMBLE : take ? LOAD_LO : DISCARD;
      end
      LOAD_LO: next = bus.phy_dv ? LOAD_HI : cnt == '0 ? DROP : TERMINATE;
      LOAD_HI: begin
        wr = bus.phy_dv && cnt < MAX;
        next = wr ? LOAD_LO : bus.phy_dv ? DISCARD : cnt == '0 ? DROP : TERMINATE;
      end
      DISCARD: next = bus.phy_dv ? DISCARD : DROP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge phy_rx_clk or posedge phy_rx_rst)
    if (phy_rx_rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge phy_rx_clk or posedge phy_rx_rst)
    if (phy_rx_rst) begin
      avail <= '0;
      cur <= '0;
      cnt <= '0;
      lo <= '0;
      counts <= '0;
      we <= '0;
      adr <= '0;
      dat <= '0;
    end else begin
      avail <= (avail | bus.rx_ready) & ~done;
      we <= wr ? cur : '0;
      if (state == LOAD_LO && bus.phy_dv) lo <= bus.phy_rx_data;
      if (take) begin
        cur <= sel;
        cnt <= '0;
      end
      if (wr) begin
        adr <= cnt[ADR_WIDTH-1:0];
        dat <= {bus.phy_rx_data, lo};
        cnt <= cnt_inc;
      end
      for (int k = 0; k < SLOTS; k++)
        if (take && sel[k]) counts[k*ADR_WIDTH +: ADR_WIDTH] <= '0;
        else if (wr && cur[k]) counts[k*ADR_WIDTH +: ADR_WIDTH] <= cnt_inc[ADR_WIDTH-1:0];
    end
`ifdef MINIMAC3_RX_ERR_EN
  logic [SLOTS-1:0] err;
  logic err_hit;
  assign err_hit = bus.phy_rx_er && (state == LOAD_LO || state == LOAD_HI) || state == LOAD_HI && !bus.phy_dv;
  always_ff @(posedge phy_rx_clk or posedge phy_rx_rst)
    if (phy_rx_rst) err <= '0;
    else
      for (int k = 0; k < SLOTS; k++)
        if (take && sel[k]) err[k] <= 1'b0;
        else if (cur[k] && err_hit) err[k] <= 1'b1;
  assign bus.rx_error = err;
`else
  logic unused_er;
  assign unused_er = bus.phy_rx_er;
  assign bus.rx_error = '0;
`endif
  assign bus.rx_done = done;
  assign bus.rx_dropped = state == DROP;
  assign bus.rx_count = counts;
  assign bus.rxb_we = we;
  assign bus.rxb_adr = adr;
  assign bus.rxb_dat = dat;
endmodule

// File: tb/tb_minimac3_rx.sv
// tb_minimac3_rx: directed frame vectors plus reset and handshake corner sequences for minimac3_rx.
module tb_minimac3_rx;
  localparam int SLOTS = 4;
  localparam int AW = 11;
  localparam int MAXL = 1536;
`ifdef MINIMAC3_RX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  minimac3_rx_if #(.SLOTS(SLOTS), .ADR_WIDTH(AW)) b();
  minimac3_rx #(.SLOTS(SLOTS), .ADR_WIDTH(AW), .MAX_LEN(MAXL)) dut (
    .phy_rx_clk(clk),
    .phy_rx_rst(rst),
    .bus(b)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ready;
    int base;
    int len;
    bit odd;
    int er_at;
    logic [3:0] done;
    int writes;
    int drops;
    int slot;
    int count;
    bit err;
  } vec_t;
  vec_t tbl [10];

  logic [7:0] mem [SLOTS][2**AW];
  int wr_slot [SLOTS];
  int wr_tot = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  logic [3:0] done_last = '0;
  int n_vec = 0;
  int n_bad = 0;

  // bus observer: sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    for (int s = 0; s < SLOTS; s++)
      if (b.rxb_we[s]) begin
        mem[s][b.rxb_adr] = b.rxb_dat;
        wr_slot[s]++;
      end
    if (b.rxb_we != '0) wr_tot++;
    if (b.rx_done != '0) begin
      done_cnt++;
      done_last = b.rx_done;
    end
    if (b.rx_dropped) drop_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic nib(input logic dv, input logic [3:0] d, input logic er);
    b.phy_dv = dv;
    b.phy_rx_data = d;
    b.phy_rx_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic byte_out(input logic [7:0] v, input logic er);
    nib(1'b1, v[3:0], er);
    nib(1'b1, v[7:4], er);
  endtask

  task automatic pulse_ready(input logic [3:0] r);
    b.rx_ready = r;
    @(posedge clk);
    #1;
    b.rx_ready = '0;
  endtask

  task automatic header();
    for (int i = 0; i < 15; i++) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hd, 1'b0);
  endtask

  task automatic send(input int base, input int len, input bit odd, input int er_at);
    header();
    for (int i = 0; i < len; i++) byte_out(8'(base + i), i == er_at);
    if (odd) nib(1'b1, 4'ha, 1'b0);
    for (int i = 0; i < 6; i++) nib(1'b0, 4'h0, 1'b0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " rx_done"}, b.rx_done, 0);
    chk({tag, " rx_count"}, b.rx_count, 0);
    chk({tag, " rx_error"}, b.rx_error, 0);
    chk({tag, " rx_dropped"}, b.rx_dropped, 0);
    chk({tag, " rxb_we"}, b.rxb_we, 0);
    chk({tag, " rxb_adr"}, b.rxb_adr, 0);
    chk({tag, " rxb_dat"}, b.rxb_dat, 0);
  endtask

  initial begin
    int sl, ws, wt, dc, dr, bad;
    tbl[0] = '{4'b0100, 'h11, 60, 0, -1, 4'b0100, 60, 0, 2, 60, 0};
    tbl[1] = '{4'b1010, 'h21, 64, 0, -1, 4'b0010, 64, 0, 1, 64, 0};
    tbl[2] = '{4'b0000, 'h61, 64, 0, -1, 4'b1000, 64, 0, 3, 64, 0};
    tbl[3] = '{4'b0000, 'h80, 64, 0, -1, 4'b0000, 0, 1, -1, 0, 0};
    tbl[4] = '{4'b0001, 'h00, 0, 0, -1, 4'b0000, 0, 1, 0, 0, 0};
    tbl[5] = '{4'b0000, 'h90, 10, 1, -1, 4'b0001, 10, 0, 0, 10, ERR_EN};
    tbl[6] = '{4'b0001, 'ha0, 64, 0, 20, 4'b0001, 64, 0, 0, 64, ERR_EN};
    tbl[7] = '{4'b0001, 'hb0, 64, 0, -1, 4'b0001, 64, 0, 0, 64, 0};
    tbl[8] = '{4'b0010, 'h00, 1600, 0, -1, 4'b0000, 1536, 1, 1, 1536, 0};
    tbl[9] = '{4'b0000, 'hc0, 64, 0, -1, 4'b0010, 64, 0, 1, 64, 0};
    b.rx_ready = '0;
    b.phy_dv = 1'b0;
    b.phy_rx_data = '0;
    b.phy_rx_er = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      sl = tbl[v].slot < 0 ? 0 : tbl[v].slot;
      ws = wr_slot[sl];
      wt = wr_tot;
      dc = done_cnt;
      dr = drop_cnt;
      pulse_ready(tbl[v].ready);
      send(tbl[v].base, tbl[v].len, tbl[v].odd, tbl[v].er_at);
      chk($sformatf("v%0d writes", v), wr_tot - wt, tbl[v].writes);
      chk($sformatf("v%0d done pulses", v), done_cnt - dc, tbl[v].done != '0 ? 1 : 0);
      chk($sformatf("v%0d drop pulses", v), drop_cnt - dr, tbl[v].drops);
      if (tbl[v].done != '0) chk($sformatf("v%0d done mask", v), done_last, tbl[v].done);
      if (tbl[v].slot >= 0) begin
        chk($sformatf("v%0d slot writes", v), wr_slot[sl] - ws, tbl[v].writes);
        chk($sformatf("v%0d rx_count", v), b.rx_count[sl*AW +: AW], tbl[v].count);
        chk($sformatf("v%0d rx_error", v), b.rx_error[sl], tbl[v].err);
        bad = 0;
        for (int i = 0; i < tbl[v].writes; i++)
          if (mem[sl][i] !== 8'(tbl[v].base + i)) bad++;
        chk($sformatf("v%0d data bytes wrong", v), bad, 0);
      end
    end

    // rx_ready colliding with rx_done on slot 0: done must win
    pulse_ready(4'b0001);
    header();
    for (int i = 0; i < 10; i++) byte_out(8'(8'h30 + i), 1'b0);
    nib(1'b0, 4'h0, 1'b0);
    chk("collide rx_done", b.rx_done, 4'b0001);
    b.rx_ready = 4'b0001;
    nib(1'b0, 4'h0, 1'b0);
    b.rx_ready = '0;
    wt = wr_tot;
    dc = done_cnt;
    dr = drop_cnt;
    send('h50, 8, 0, -1);
    chk("collide writes", wr_tot - wt, 0);
    chk("collide done pulses", done_cnt - dc, 0);
    chk("collide drop pulses", drop_cnt - dr, 1);

    // reset in the middle of a frame
    pulse_ready(4'b0010);
    header();
    for (int i = 0; i < 20; i++) byte_out(8'(8'h70 + i), 1'b0);
    chk("pre-reset rx_count", b.rx_count[AW +: AW], 20);
    rst = 1'b1;
    nib(1'b1, 4'ha, 1'b0);
    nib(1'b1, 4'h3, 1'b0);
    nib(1'b1, 4'ha, 1'b0);
    chk_idle_outputs("mid-frame reset");
    rst = 1'b0;
    wt = wr_tot;
    dc = done_cnt;
    dr = drop_cnt;
    for (int i = 0; i < 10; i++) byte_out(8'h3a, 1'b0);
    for (int i = 0; i < 6; i++) nib(1'b0, 4'h0, 1'b0);
    chk("post-reset writes", wr_tot - wt, 0);
    chk("post-reset done pulses", done_cnt - dc, 0);
    chk("post-reset drop pulses", drop_cnt - dr, 1);
    wt = wr_tot;
    dr = drop_cnt;
    send('h10, 8, 0, -1);
    chk("no slot after reset writes", wr_tot - wt, 0);
    chk("no slot after reset drops", drop_cnt - dr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
